// File: rtl/tri_inv_pkg.sv
// Shared types and helpers for the lower-triangular matrix inverter.
package tri_inv_pkg;

  typedef enum logic [2:0] {IDLE, DIAG, MAC, FIN, FINISH} state_t;

  // Bit offset of element (r,c) in a row-major packed n x n matrix of w-bit words.
  function automatic int idx(input int r, input int c, input int n, input int w);
    return w * (r * n + c);
  endfunction

  // Accumulator width: element width plus headroom for n partial sums and sign.
  function automatic int acc_width(input int n, input int w);
    return w + $clog2(n) + 1;
  endfunction

  localparam int ACC_W_DEFAULT = acc_width(3, 16);

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tri_inv_sequencer_fxp_mac.sv
// Fixed-point multiply-accumulate: a*b >>> FRAC, accumulated with clear/enable,
// plus a combinational W-bit saturated view of the shifted product.
module fxp_mac
  import tri_inv_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int AW   = 19,
  parameter int AWA  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic signed [AWA-1:0] a,
  input  logic signed [W-1:0]   b,
  output logic signed [AW-1:0]  acc,
  output logic signed [W-1:0]   sat
);

  localparam int PW = AWA + W;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;

  assign prod    = PW'(a) * PW'(b);
  assign prod_sh = prod >>> FRAC;
  assign sat     = W'(sat_w(64'(prod_sh), W));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + AW'(prod_sh);
  end

endmodule

// File: rtl/tri_inv_sequencer.sv
// Inverts an N x N lower-triangular fixed-point matrix by forward substitution,
// borrowing an external reciprocal unit for the diagonal.
module tri_inv_sequencer
  import tri_inv_pkg::*;
#(
  parameter int N    = 3,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W*N*N-1:0] L_in,
  output logic             busy,
  output logic             done,
  output logic             err_singular,
  output logic [W*N*N-1:0] L_inv_out,
  output logic             recip_req,
  output logic [W-1:0]     recip_operand,
  input  logic             recip_valid,
  input  logic [W-1:0]     recip_result
);

  localparam int AW  = acc_width(N, W);
  localparam int AWA = AW + 1;
  localparam int IW  = $clog2(N);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);
  localparam logic [IW-1:0] LAST_J = IW'(N - 2);

  state_t state, state_next;
  logic [IW-1:0] i, j, k;
  logic signed [W-1:0] l_reg [N][N];
  logic signed [W-1:0] inv   [N][N];
  logic diag_zero, accept, last_pair, mac_clear, mac_en;
  logic signed [AWA-1:0] mac_a;
  logic signed [W-1:0]   mac_b, mac_sat;
  logic signed [AW-1:0]  acc;
  logic [W*N*N-1:0]      inv_flat;

  assign diag_zero = (l_reg[i][i] == '0);
  assign accept    = recip_req && recip_valid;
  assign last_pair = (i == LAST_I) && (j == LAST_J);
  assign mac_en    = (state == MAC);
  assign mac_clear = (state == FIN) || ((state == DIAG) && accept && (i == LAST_I));
  // FIN reuses the multiplier: -acc * inv[i][i] at full accumulator precision.
  assign mac_a     = (state == FIN) ? -AWA'(acc) : AWA'(l_reg[i][k]);
  assign mac_b     = (state == FIN) ? inv[i][i] : inv[k][j];

  fxp_mac #(.W(W), .FRAC(FRAC), .AW(AW), .AWA(AWA)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc),
    .sat   (mac_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = DIAG;
      DIAG:    if (diag_zero) state_next = FINISH;
               else if (accept && (i == LAST_I)) state_next = MAC;
      MAC:     if (k == i - IW'(1)) state_next = FIN;
      FIN:     state_next = last_pair ? FINISH : MAC;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    recip_req     = 1'b0;
    recip_operand = '0;
    unique case (state)
      DIAG: begin
        busy = 1'b1;
        if (!diag_zero) begin
          recip_req     = 1'b1;
          recip_operand = l_reg[i][i];
        end
      end
      MAC, FIN: busy = 1'b1;
      FINISH:   done = 1'b1;
      default: ;
    endcase
  end

  // Final result with the last off-diagonal element taken straight from the multiplier.
  always_comb begin
    inv_flat = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (c <= r) inv_flat[idx(r, c, N, W) +: W] = inv[r][c];
    inv_flat[idx(N - 1, N - 2, N, W) +: W] = mac_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i            <= '0;
      j            <= '0;
      k            <= '0;
      err_singular <= 1'b0;
      L_inv_out    <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          err_singular <= 1'b0;
          i            <= '0;
          j            <= '0;
          k            <= '0;
        end
        DIAG: begin
          if (diag_zero) err_singular <= 1'b1;
          else if (accept) begin
            if (i == LAST_I) begin
              i <= IW'(1);
              j <= '0;
              k <= '0;
            end else begin
              i <= i + IW'(1);
            end
          end
        end
        MAC: k <= k + IW'(1);
        FIN: begin
          if (j + IW'(1) == i) begin
            i <= i + IW'(1);
            j <= '0;
            k <= '0;
          end else begin
            j <= j + IW'(1);
            k <= j + IW'(1);
          end
          if (last_pair) L_inv_out <= inv_flat;
        end
        default: ;
      endcase
    end
  end

  // NOTE: matrix storage has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          l_reg[r][c] <= L_in[idx(r, c, N, W) +: W];
    if ((state == DIAG) && accept) inv[i][i] <= recip_result;
    if (state == FIN)              inv[i][j] <= mac_sat;
  end

endmodule

// File: tb/tb_tri_inv_sequencer.sv
// Directed bench for tri_inv_sequencer (N=3, W=16, FRAC=8) with a delayed
// reciprocal responder model.
module tb_tri_inv_sequencer;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int MW = W * N * N;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [MW-1:0] L_in;
  logic          busy, done, err_singular;
  logic [MW-1:0] L_inv_out;
  logic          recip_req;
  logic [W-1:0]  recip_operand;
  logic          recip_valid;
  logic [W-1:0]  recip_result;

  int checks = 0;
  int errors = 0;
  int delay = 3;
  int wait_cnt = 0;
  int hs_count = 0;
  int unstable = 0;
  logic [W-1:0] held_op, first_op;

  tri_inv_sequencer #(.N(N), .W(W), .FRAC(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .L_in          (L_in),
    .busy          (busy),
    .done          (done),
    .err_singular  (err_singular),
    .L_inv_out     (L_inv_out),
    .recip_req     (recip_req),
    .recip_operand (recip_operand),
    .recip_valid   (recip_valid),
    .recip_result  (recip_result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] recip_of(input logic [W-1:0] op);
    int v;
    v = int'($signed(op));
    if (v == 0) return '0;
    return W'(65536 / v);
  endfunction

  // Reciprocal unit: answers in the cycle 'delay' cycles after the request is first seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      recip_valid = 1'b0;
      wait_cnt    = 0;
    end else begin
      if (recip_valid) begin
        recip_valid = 1'b0;
        wait_cnt    = 0;
      end
      if (recip_req) begin
        if (wait_cnt == 0) held_op = recip_operand;
        else if (recip_operand != held_op) unstable++;
        if (wait_cnt == delay) begin
          recip_valid  = 1'b1;
          recip_result = recip_of(recip_operand);
          if (hs_count == 0) first_op = recip_operand;
          hs_count++;
        end else begin
          wait_cnt++;
        end
      end else if (wait_cnt > 0) begin
        unstable++;
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input logic [W-1:0] e00, e10, e11, e20, e21, e22, u);
    logic [MW-1:0] v;
    v = '0;
    v[0   +: W] = e00;  v[16  +: W] = u;    v[32  +: W] = u;
    v[48  +: W] = e10;  v[64  +: W] = e11;  v[80  +: W] = u;
    v[96  +: W] = e20;  v[112 +: W] = e21;  v[128 +: W] = e22;
    return v;
  endfunction

  // Starts one inversion; latency counts cycles inclusively from the start cycle to the done cycle.
  task automatic run_matrix(input logic [MW-1:0] m, input int dly, input int pulse_cyc,
                            output int lat, output int n_done, output logic busy2);
    int cyc;
    lat = 0; n_done = 0; busy2 = 1'b0;
    @(negedge clk);
    L_in = m; delay = dly; hs_count = 0; unstable = 0; first_op = '0;
    start = 1'b1;
    cyc = 1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_cyc);
      if (cyc == 2) busy2 = busy;
      if (done) begin
        n_done++;
        if (lat == 0) lat = cyc;
      end
      if (lat != 0 && cyc >= lat + 3) break;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [MW-1:0] m;
    int            dly;
    logic [MW-1:0] exp_out;
    logic          exp_err;
    int            exp_lat;
    int            exp_hs;
    logic [W-1:0]  exp_first;
  } vec_t;

  vec_t vecs [4];
  logic [MW-1:0] ident_in, ident_out, case2_in, case2_out, sing_in, junk_in;
  int lat, nd;
  logic b2;

  initial begin
    ident_in  = mk(16'h0100, 0, 16'h0100, 0, 0, 16'h0100, 0);
    ident_out = ident_in;
    case2_in  = mk(16'h0200, 16'h0100, 16'h0400, 16'h0000, 16'h0200, 16'h0800, 0);
    case2_out = mk(16'h0080, 16'hFFE0, 16'h0040, 16'h0008, 16'hFFF0, 16'h0020, 0);
    sing_in   = mk(16'h0200, 16'h0100, 16'h0000, 16'h0000, 16'h0200, 16'h0800, 0);
    junk_in   = mk(16'h0200, 16'h0100, 16'h0400, 16'h0000, 16'h0200, 16'h0800, 16'h7FFF);

    vecs[0] = '{ident_in, 3, ident_out, 1'b0, 21, 3, 16'h0100};
    vecs[1] = '{case2_in, 3, case2_out, 1'b0, 21, 3, 16'h0200};
    vecs[2] = '{sing_in,  3, case2_out, 1'b1,  7, 1, 16'h0200};
    vecs[3] = '{junk_in, 10, case2_out, 1'b0, 42, 3, 16'h0200};

    rst_n = 1'b0; start = 1'b0; L_in = '0; recip_valid = 1'b0; recip_result = '0;
    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_singular, 0);
    check("reset_out", L_inv_out, 0);
    check("reset_req", recip_req, 0);
    check("reset_operand", recip_operand, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_matrix(vecs[v].m, vecs[v].dly, 0, lat, nd, b2);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_done_count", v), nd, 1);
      check($sformatf("v%0d_busy_after_start", v), b2, 1);
      check($sformatf("v%0d_out", v), L_inv_out, vecs[v].exp_out);
      check($sformatf("v%0d_err", v), err_singular, vecs[v].exp_err);
      check($sformatf("v%0d_handshakes", v), hs_count, vecs[v].exp_hs);
      check($sformatf("v%0d_first_operand", v), first_op, vecs[v].exp_first);
      check($sformatf("v%0d_req_stable", v), unstable, 0);
      check($sformatf("v%0d_idle_after", v), {busy, recip_req}, 0);
    end

    // Spurious reciprocal response while idle must not disturb anything.
    @(negedge clk);
    #2;
    recip_valid = 1'b1; recip_result = 16'h1234;
    nd = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("spurious_no_activity", nd, 0);
    check("spurious_out_kept", L_inv_out, case2_out);

    run_matrix(ident_in, 3, 0, lat, nd, b2);
    check("ident2_out", L_inv_out, ident_out);

    // start pulsed in cycle 16 (inside the MAC/FIN phase) must be ignored.
    run_matrix(case2_in, 3, 16, lat, nd, b2);
    check("midstart_latency", lat, 21);
    check("midstart_done_count", nd, 1);
    check("midstart_out", L_inv_out, case2_out);
    check("midstart_idle", busy, 0);

    // Reset asserted while waiting on the reciprocal unit.
    @(negedge clk);
    L_in = case2_in; delay = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_req_before", recip_req, 1);
    rst_n = 1'b0;
    #1;
    check("abort_req", recip_req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", L_inv_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_matrix(ident_in, 3, 0, lat, nd, b2);
    check("post_abort_latency", lat, 21);
    check("post_abort_done_count", nd, 1);
    check("post_abort_out", L_inv_out, ident_out);
    check("post_abort_err", err_singular, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
